// File: rtl/alu_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_4bit
//  Description : 4-bit ALU with registered 5-bit result (bit 4 carries the
//                carry / borrow / shift-out) and a registered in_a == 0 flag.
//                One operation accepted per clock, one-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    input  logic [3:0] opcode,
    output logic [4:0] alu_out,
    output logic       a_in_zero
);

    localparam logic [3:0] c_OP_PASS = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_XOR  = 4'd5;
    localparam logic [3:0] c_OP_SHL  = 4'd6;
    localparam logic [3:0] c_OP_SHR  = 4'd7;
    localparam logic [3:0] c_OP_INC  = 4'd8;
    localparam logic [3:0] c_OP_DEC  = 4'd9;
    localparam logic [3:0] c_OP_GT   = 4'd10;

    // Operands zero-extended so bit 4 naturally captures carry and borrow.
    logic [4:0] w_a_ext;
    logic [4:0] w_b_ext;
    logic [4:0] w_result;
    logic [4:0] r_alu_out;
    logic       r_a_in_zero;

    assign w_a_ext = {1'b0, in_a};
    assign w_b_ext = {1'b0, in_b};

    // Combinational datapath: select the 5-bit result for the current opcode.
    always_comb begin
        w_result = 5'd0;
        case (opcode)
            c_OP_PASS: w_result = w_a_ext;
            c_OP_ADD:  w_result = w_a_ext + w_b_ext;
            c_OP_SUB:  w_result = w_a_ext - w_b_ext;
            c_OP_AND:  w_result = w_a_ext & w_b_ext;
            c_OP_OR:   w_result = w_a_ext | w_b_ext;
            c_OP_XOR:  w_result = w_a_ext ^ w_b_ext;
            c_OP_SHL:  w_result = {in_a, 1'b0};
            c_OP_SHR:  w_result = {2'b00, in_a[3:1]};
            c_OP_INC:  w_result = w_a_ext + 5'd1;
            c_OP_DEC:  w_result = w_a_ext - 5'd1;
            c_OP_GT:   w_result = (in_a > in_b) ? 5'd1 : 5'd0;
            default:   w_result = 5'd0;
        endcase
    end

    // Output registers; reset wins over any operation in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_out   <= 5'd0;
            r_a_in_zero <= 1'b0;
        end else begin
            r_alu_out   <= w_result;
            r_a_in_zero <= (in_a == 4'd0);
        end
    end

    assign alu_out   = r_alu_out;
    assign a_in_zero = r_a_in_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_4bit
//  Description : Directed self-checking bench for alu_4bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] opcode;
    logic [4:0] alu_out;
    logic       a_in_zero;

    int r_checks = 0;
    int r_errors = 0;

    alu_4bit u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .opcode    (opcode),
        .alu_out   (alu_out),
        .a_in_zero (a_in_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic apply(input logic r, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        rst    = r;
        opcode = op;
        in_a   = a;
        in_b   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [4:0] exp_out, input logic exp_z);
        apply(1'b0, op, a, b);
        check({tag, ".out"}, alu_out, exp_out);
        check({tag, ".zero"}, {4'd0, a_in_zero}, {4'd0, exp_z});
    endtask

    initial begin
        rst = 1'b1; opcode = 4'd0; in_a = 4'd0; in_b = 4'd0;
        // Reset with in_a == 0: flag must still read 0.
        apply(1'b1, 4'd0, 4'd0, 4'd0);
        apply(1'b1, 4'd0, 4'd0, 4'd0);
        check("reset.out", alu_out, 5'd0);
        check("reset.zero", {4'd0, a_in_zero}, 5'd0);

        vec("add_7_15",  4'd1,  4'd7,  4'd15, 5'd22, 1'b0);
        vec("add_15_15", 4'd1,  4'd15, 4'd15, 5'd30, 1'b0);
        vec("sub_7_15",  4'd2,  4'd7,  4'd15, 5'd24, 1'b0);
        vec("sub_0_1",   4'd2,  4'd0,  4'd1,  5'd31, 1'b1);
        vec("sub_9_4",   4'd2,  4'd9,  4'd4,  5'd5,  1'b0);
        vec("pass_11",   4'd0,  4'd11, 4'd2,  5'd11, 1'b0);
        vec("and_12_15", 4'd3,  4'd12, 4'd15, 5'd12, 1'b0);
        vec("or_7_0",    4'd4,  4'd7,  4'd0,  5'd7,  1'b0);
        vec("xor_1_3",   4'd5,  4'd1,  4'd3,  5'd2,  1'b0);
        vec("shl_7",     4'd6,  4'd7,  4'd0,  5'd14, 1'b0);
        vec("shl_9",     4'd6,  4'd9,  4'd0,  5'd18, 1'b0);
        vec("shr_7",     4'd7,  4'd7,  4'd0,  5'd3,  1'b0);
        vec("shr_8",     4'd7,  4'd8,  4'd0,  5'd4,  1'b0);
        vec("inc_7",     4'd8,  4'd7,  4'd0,  5'd8,  1'b0);
        vec("dec_7",     4'd9,  4'd7,  4'd0,  5'd6,  1'b0);
        vec("inc_15",    4'd8,  4'd15, 4'd0,  5'd16, 1'b0);
        vec("dec_0",     4'd9,  4'd0,  4'd0,  5'd31, 1'b1);
        vec("gt_7_3",    4'd10, 4'd7,  4'd3,  5'd1,  1'b0);
        vec("gt_3_7",    4'd10, 4'd3,  4'd7,  5'd0,  1'b0);
        vec("gt_5_5",    4'd10, 4'd5,  4'd5,  5'd0,  1'b0);
        vec("rsv_12",    4'd12, 4'd7,  4'd3,  5'd0,  1'b0);
        vec("rsv_11",    4'd11, 4'd15, 4'd15, 5'd0,  1'b0);
        vec("rsv_15_z",  4'd15, 4'd0,  4'd9,  5'd0,  1'b1);
        vec("and_0_z",   4'd3,  4'd0,  4'd15, 5'd0,  1'b1);

        // Reset takes priority over a live operation, then result follows.
        apply(1'b1, 4'd1, 4'd7, 4'd15);
        check("rst_mid.out", alu_out, 5'd0);
        check("rst_mid.zero", {4'd0, a_in_zero}, 5'd0);
        apply(1'b0, 4'd1, 4'd7, 4'd15);
        check("rst_rel.out", alu_out, 5'd22);

        // Mid-cycle input change must not reach the output before the edge.
        @(negedge clk);
        opcode = 4'd0; in_a = 4'd3; in_b = 4'd0;
        #1;
        check("latency.hold", alu_out, 5'd22);
        check("latency.hold_z", {4'd0, a_in_zero}, 5'd0);
        @(posedge clk);
        #1;
        check("latency.update", alu_out, 5'd3);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The port list SHALL be as follows (clock and reset first):
  - clk        input   1  single clock; all state updates on rising edge.
  - rst        input   1  synchronous, active-high reset.
  - in_a       input   4  operand A, unsigned.
  - in_b       input   4  operand B, unsigned.
  - opcode     input   4  operation select.
  - alu_out    output  5  registered result; bit 4 = carry/borrow/shift-out.
  - a_in_zero  output  1  registered flag, 1 when in_a == 0.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 The block SHALL sample in_a, in_b and opcode on each rising clk edge with rst low.
- The result appears on alu_out after that same edge: 1-cycle latency, no handshake.
- A new operation is accepted every cycle.
REQ-005 Opcode map; zero-extend operands to 5 bits before evaluating:
  - 0   pass A: {0,in_a}.
  - 1   ADD: in_a + in_b; bit 4 = carry out.
  - 2   SUB: {0,in_a} - {0,in_b} mod 32; bit 4 = 1 on borrow (in_a < in_b).
  - 3   AND: {0, in_a & in_b}.
  - 4   OR: {0, in_a | in_b}.
  - 5   XOR: {0, in_a ^ in_b}.
  - 6   SHL: {in_a, 0}; bit 4 = old in_a[3].
  - 7   SHR: {0, 0, in_a[3:1]}, logical shift.
  - 8   INC: in_a + 1; bit 4 = carry (15 -> 16).
  - 9   DEC: {0,in_a} - 1 mod 32 (0 -> 31).
  - 10  GT: 1 if in_a > in_b (unsigned), else 0.
  - 11-15  reserved: alu_out = 0.
REQ-006 Wrap-around: ADD max 15+15 = 30; SUB 0-1 = 31; DEC 0 = 31; no saturation.
REQ-007 a_in_zero SHALL register (in_a == 4'd0) on every non-reset edge, for every opcode including reserved ones.
REQ-008 The datapath SHALL be purely combinational ahead of the output registers; there are no other state elements.
REQ-009 Inputs changing between edges SHALL have no effect on outputs until the next edge.

Reset
REQ-010 With rst high at a rising edge, alu_out SHALL become 5'd0 and a_in_zero SHALL become 0, regardless of inputs.
REQ-011 Reset SHALL take priority over any operation in the same cycle.
- A reset mid-stream discards the pending result.
- The first post-reset result appears one edge after rst deasserts.
REQ-012 Before the first reset, output values are undefined; the bench SHALL apply reset first.

Verification
REQ-013 Arithmetic:
- op 1, A=7, B=15 -> alu_out = 22 (5'b10110), a_in_zero = 0.
- op 2, A=7, B=15 -> alu_out = 24 (5'b11000, borrow set).
REQ-014 Logic:
- op 3, A=12, B=15 -> 12.
- op 4, A=7, B=0 -> 7.
- op 5, A=1, B=3 -> 2.
REQ-015 Shift, increment, decrement:
- op 6, A=7 -> 14.
- op 7, A=7 -> 3.
- op 8, A=7 -> 8.
- op 9, A=7 -> 6.
- op 8, A=15 -> 16.
- op 9, A=0 -> 31.
REQ-016 Compare, reserved and flag:
- op 10, A=7, B=3 -> 1; A=3, B=7 -> 0.
- op 12 -> 0.
- A=0 with any opcode -> a_in_zero = 1 one edge later.
REQ-017 Reset: assert rst during op 1, A=7, B=15 -> alu_out = 0 and a_in_zero = 0 at that edge; deassert -> 22 on the next edge.
REQ-018 Latency: change inputs mid-cycle -> alu_out changes only at the next rising clk edge.
